// File: rtl/cla_seq_ctrl.sv
// cla_seq_ctrl: W-bit adder that reuses one 4-bit carry-lookahead cell, one nibble per cycle, LSB first.
// Optional signed-overflow output `ovf` is built only when CLA_SEQ_OVF_EN is defined.

module cla_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [3:0] g_s;
  logic [3:0] p_s;
  logic [4:0] c_s;

  // Generate/propagate lookahead carries for one nibble
  always_comb begin
    g_s    = a_i & b_i;
    p_s    = a_i ^ b_i;
    c_s[0] = c_i;
    c_s[1] = g_s[0] | (p_s[0] & c_i);
    c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c_i);
    c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
           | (p_s[2] & p_s[1] & p_s[0] & c_i);
    c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
           | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
           | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c_i);
    s_o    = p_s ^ c_s[3:0];
    c_o    = c_s[4];
  end
endmodule

module cla_seq_ctrl #(
  parameter int N_NIB = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*N_NIB-1:0]   a,
  input  logic [4*N_NIB-1:0]   b,
  input  logic                 c_in,
  output logic                 busy,
  output logic                 done,
  output logic [4*N_NIB-1:0]   sum,
`ifdef CLA_SEQ_OVF_EN
  output logic                 ovf,
`endif
  output logic                 c_out
);
  localparam int W    = 4 * N_NIB;
  localparam int IDXW = (N_NIB > 1) ? $clog2(N_NIB) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N_NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [IDXW-1:0] idx_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    sum_q;
  logic            carry_q;
  logic            c_out_q;
  logic            busy_q;
  logic            done_q;
`ifdef CLA_SEQ_OVF_EN
  logic            ovf_q;
`endif

  logic [3:0]      nib_a_s;
  logic [3:0]      nib_b_s;
  logic [3:0]      nib_sum_s;
  logic            nib_carry_s;

  // Select the operand nibbles for the current step
  always_comb begin
    nib_a_s = a_q[{idx_q, 2'b00} +: 4];
    nib_b_s = b_q[{idx_q, 2'b00} +: 4];
  end

  cla_4bit u_cla (
    .a_i (nib_a_s),
    .b_i (nib_b_s),
    .c_i (carry_q),
    .s_o (nib_sum_s),
    .c_o (nib_carry_s)
  );

  // Control FSM with registered status and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= c_in;
            sum_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ADD;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_ADD: begin
          sum_q[{idx_q, 2'b00} +: 4] <= nib_sum_s;
          carry_q <= nib_carry_s;
          if (idx_q == IDX_LAST) begin
            // Final nibble: the CLA carry is the carry-out of the whole word
            idx_q   <= '0;
            c_out_q <= nib_carry_s;
            done_q  <= 1'b1;
            state_q <= S_DONE;
`ifdef CLA_SEQ_OVF_EN
            ovf_q   <= (a_q[W-1] == b_q[W-1]) && (nib_sum_s[3] != a_q[W-1]);
`endif
          end else begin
            idx_q   <= idx_q + IDXW'(1);
            state_q <= S_ADD;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          idx_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;
`ifdef CLA_SEQ_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Directed bench for cla_seq_ctrl (N_NIB=4); ovf checks are built when CLA_SEQ_OVF_EN is defined.
`timescale 1ns/1ps

module tb_cla_seq_ctrl;
  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        c_out;
`ifdef CLA_SEQ_OVF_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  cla_seq_ctrl #(.N_NIB(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef CLA_SEQ_OVF_EN
    .ovf   (ovf),
`endif
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts an add, checks exact busy/done timing, result and hold; inj (1..4) injects an ignored start
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                        input logic [15:0] es, input logic ec, input int inj);
    a = av; b = bv; c_in = cv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; c_in = ~cv;
    check("sum_cleared_on_accept", 32'(sum), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      if (k == inj) begin
        a = ~av; b = bv ^ 16'h5A5A; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      check("busy_during_op", 32'(busy), 32'h1);
      check("done_timing", 32'(done), (k == 5) ? 32'h1 : 32'h0);
      if (k < 5) @(negedge clk);
    end
    start = 1'b0;
    check("sum_at_done", 32'(sum), 32'(es));
    check("c_out_at_done", 32'(c_out), 32'(ec));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("busy_after_done", 32'(busy), 32'h0);
      check("done_single_pulse", 32'(done), 32'h0);
      check("sum_held", 32'(sum), 32'(es));
      check("c_out_held", 32'(c_out), 32'(ec));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0; c_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_sum", 32'(sum), 32'h0);
    check("reset_c_out", 32'(c_out), 32'h0);
`ifdef CLA_SEQ_OVF_EN
    check("reset_ovf", 32'(ovf), 32'h0);
`endif
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0);
`ifdef CLA_SEQ_OVF_EN
    check("ovf_none", 32'(ovf), 32'h0);
`endif
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0);
    run_op(16'hA5C3, 16'h5A3C, 1'b1, 16'h0000, 1'b1, 2);
    run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 0);
    run_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 4);
    run_op(16'h8001, 16'h8002, 1'b1, 16'h0004, 1'b1, 0);

    // Abort mid-operation; start held with rst must lose to reset
    a = 16'h1234; b = 16'h4321; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_busy_before", 32'(busy), 32'h1);
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_sum", 32'(sum), 32'h0);
    check("abort_c_out", 32'(c_out), 32'h0);
    rst = 1'b0; start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'h0);
      check("abort_stays_idle", 32'(busy), 32'h0);
    end
    run_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 0);

`ifdef CLA_SEQ_OVF_EN
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 0);
    check("ovf_pos", 32'(ovf), 32'h1);
    run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 0);
    check("ovf_neg", 32'(ovf), 32'h1);
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 0);
    check("ovf_neg_none", 32'(ovf), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cla_seq_ctrl.md
CLA_SEQ_CTRL -- requirements
Module: cla_seq_ctrl

Interface
REQ-001 SHALL have parameter N_NIB, default 4, giving the operand width in 4-bit nibbles (W = 4*N_NIB, N_NIB >= 2).
REQ-002 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-004 SHALL have port start  input  1  request to add a, b and c_in.
REQ-005 SHALL have port a  input  W  operand A, sampled only on an accepted start.
REQ-006 SHALL have port b  input  W  operand B, sampled only on an accepted start.
REQ-007 SHALL have port c_in  input  1  carry-in, sampled only on an accepted start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse marking a valid result.
REQ-010 SHALL have port sum  output  W  registered result.
REQ-011 SHALL have port c_out  output  1  registered carry-out of the full W-bit addition.

Function
REQ-012 SHALL compute every result with exactly one internal cla_4bit instance, time-shared over N_NIB cycles, LSB nibble first.
REQ-013 SHALL implement the states IDLE, ADD and DONE, with an index counter idx of width ceil(log2(N_NIB)).
REQ-014 In IDLE with start=1, SHALL latch a, b and c_in, clear sum to 0, set idx=0 and enter ADD at that edge. This edge is the accept edge.
REQ-015 In ADD, each edge SHALL write nibble idx of sum from the CLA fed by latched nibble idx of a and b and the carry register, load the carry register from the CLA c_out, and increment idx.
REQ-016 SHALL leave ADD for DONE at the edge that processes idx = N_NIB-1, and load c_out from the CLA carry at that edge.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-018 SHALL be high on done exactly N_NIB+1 edges after the accept edge; with N_NIB=4, done is high in the cycle after the 5th edge, counting the accept edge as the 1st.
REQ-019 busy SHALL be 1 in ADD and DONE, and 0 in IDLE.
REQ-020 SHALL ignore start while busy=1; a, b and c_in changes while busy SHALL NOT affect the result.
REQ-021 SHALL hold sum and c_out at the last result from DONE until the next accept edge.
REQ-022 Arithmetic: {c_out, sum} SHALL equal a + b + c_in modulo 2^(W+1), with operands unsigned; a carry SHALL propagate across every nibble boundary.

Reset
REQ-023 On rst=1 at a rising edge, SHALL set: state IDLE, idx 0, carry register 0, sum 0, c_out 0, busy 0, done 0.
REQ-024 Reset SHALL take priority over start in the same cycle.
REQ-025 Reset during ADD or DONE SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-026 With macro CLA_SEQ_OVF_EN defined, SHALL add port ovf  output  1: signed overflow, registered at the DONE transition, equal to (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]) using the latched operands, reset to 0, held like sum.
REQ-027 Without CLA_SEQ_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (N_NIB=4)
REQ-028 SHALL cover: a=0x1234, b=0x4321, c_in=0, start for 1 cycle -> busy high 5 cycles, done pulse at edge 5, sum=0x5555, c_out=0.
REQ-029 SHALL cover: a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1 (carry ripples through all four nibbles).
REQ-030 SHALL cover: a=0xA5C3, b=0x5A3C, c_in=1 -> sum=0x0000, c_out=1; a second start with new operands 2 cycles after accept -> ignored, exactly one done, result unchanged.
REQ-031 SHALL cover: start accepted, rst=1 at the 3rd cycle -> no done, sum=0, c_out=0, busy=0; next start a=0x0F0F, b=0x00F1, c_in=0 -> sum=0x1000, c_out=0.
REQ-032 SHALL cover, with CLA_SEQ_OVF_EN: a=0x7FFF, b=0x0001, c_in=0 -> sum=0x8000, ovf=1, c_out=0; a=0x8000, b=0x8000 -> sum=0x0000, ovf=1, c_out=1.
